// File: rtl/fpdiv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fpdiv_seq_ctrl
//
// Moore sequencer for a Goldschmidt floating-point divider datapath. It first
// scales the numerator and the divisor by a constant seed (0.75), then runs
// ITER refinement steps. Each step multiplies the numerator and the divisor by
// the correction factor C = ~B, which is the one's complement of the divisor.
// A one-cycle done pulse marks the cycle in which register A holds the
// quotient.
//
// The multiplication chain is:
//   N0 : A <= seed * num
//   D0 : B <= seed * denom, C <= ~(seed * denom)
//   NI : A <= C * A
//   DI : B <= C * B,        C <= ~(C * B)
// The last DI is skipped because its divisor update would never be used.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset; forces IDLE
//   start     in   divide request, sampled only in IDLE or DONE
//   abort     in   synchronous cancel of an in-flight divide
//   sel_mux2  out  multiplier-A select: 0 = seed, 1 = register C
//   sel_mux4  out  multiplier-B select: 00 num, 01 denom, 10 reg A, 11 reg B
//   en_a      out  load enable, register A (quotient)
//   en_b      out  load enable, register B (divisor)
//   en_c      out  load enable, register C (correction factor)
//   busy      out  a divide is in flight
//   ready     out  start will be accepted this cycle
//   done      out  one-cycle pulse; register A holds the quotient
//   iter_cnt  out  current refinement index (debug / verification)
//
// Every output decodes from registered state only, so there is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
module fpdiv_seq_ctrl #(
  parameter int ITER  = 3,   // refinement steps after initial scaling, 1..15
  parameter int CNT_W = 4    // counter width, 2**CNT_W > ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             sel_mux2,
  output logic [1:0]       sel_mux4,
  output logic             en_a,
  output logic             en_b,
  output logic             en_c,
  output logic             busy,
  output logic             ready,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_N0   = 3'd1,
    S_D0   = 3'd2,
    S_NI   = 3'd3,
    S_DI   = 3'd4,
    S_DONE = 3'd5
  } state_e;

  // Encodings of the multiplier-B mux.
  localparam logic [1:0] MUXB_NUM   = 2'b00;
  localparam logic [1:0] MUXB_DENOM = 2'b01;
  localparam logic [1:0] MUXB_REGA  = 2'b10;
  localparam logic [1:0] MUXB_REGB  = 2'b11;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, whatever order the processes run in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before the case statement. A branch
  // that does not assign a variable therefore keeps the default and no latch
  // is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        // abort is ignored here, so start always wins.
        if (start) state_d = S_N0;
      end

      S_N0: begin
        if (abort) state_d = S_IDLE;
        else       state_d = S_D0;
      end

      S_D0: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_NI;
          cnt_d   = '0;
        end
      end

      S_NI: begin
        if (abort)                   state_d = S_IDLE;
        else if (cnt_q == LAST_ITER) state_d = S_DONE;
        else                         state_d = S_DI;
      end

      S_DI: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_NI;
          cnt_d   = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        // Back-to-back issue: a waiting start goes straight to N0, so the
        // datapath never sits idle between requests.
        if (start) state_d = S_N0;
        else       state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_mux2 = 1'b0;
    sel_mux4 = MUXB_NUM;
    en_a     = 1'b0;
    en_b     = 1'b0;
    en_c     = 1'b0;
    busy     = 1'b0;
    ready    = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
      end

      S_N0: begin
        busy     = 1'b1;
        sel_mux2 = 1'b0;
        sel_mux4 = MUXB_NUM;
        en_a     = 1'b1;
      end

      S_D0: begin
        busy     = 1'b1;
        sel_mux2 = 1'b0;
        sel_mux4 = MUXB_DENOM;
        en_b     = 1'b1;
        en_c     = 1'b1;
      end

      S_NI: begin
        busy     = 1'b1;
        sel_mux2 = 1'b1;
        sel_mux4 = MUXB_REGA;
        en_a     = 1'b1;
      end

      S_DI: begin
        busy     = 1'b1;
        sel_mux2 = 1'b1;
        sel_mux4 = MUXB_REGB;
        en_b     = 1'b1;
        en_c     = 1'b1;
      end

      S_DONE: begin
        done  = 1'b1;
        ready = 1'b1;
      end

      default: begin
        ready = 1'b1;
      end
    endcase
  end

  assign iter_cnt = cnt_q;

endmodule

// File: tb/tb_fpdiv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for fpdiv_seq_ctrl. It instantiates the controller twice,
// once with ITER=3 and once with ITER=1. A fixed-point Goldschmidt datapath
// (Q1.16, 17-bit registers) is driven by the ITER=3 controls, so the quotient
// can be checked as well as the control sequence.
// -----------------------------------------------------------------------------
module tb_fpdiv_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, abort, start1, abort1;
  logic       sel_mux2, en_a, en_b, en_c, busy, ready, done;
  logic [1:0] sel_mux4;
  logic [3:0] iter_cnt;
  logic       sel_mux2_1, en_a_1, en_b_1, en_c_1, busy_1, ready_1, done_1;
  logic [1:0] sel_mux4_1;
  logic [3:0] iter_cnt_1;

  fpdiv_seq_ctrl #(.ITER(3), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .sel_mux2(sel_mux2), .sel_mux4(sel_mux4), .en_a(en_a), .en_b(en_b),
    .en_c(en_c), .busy(busy), .ready(ready), .done(done), .iter_cnt(iter_cnt)
  );

  fpdiv_seq_ctrl #(.ITER(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .sel_mux2(sel_mux2_1), .sel_mux4(sel_mux4_1), .en_a(en_a_1), .en_b(en_b_1),
    .en_c(en_c_1), .busy(busy_1), .ready(ready_1), .done(done_1),
    .iter_cnt(iter_cnt_1)
  );

  // Output vector: {sel_mux2, sel_mux4, en_a, en_b, en_c, busy, ready, done}
  logic [8:0] outs, outs1;
  assign outs  = {sel_mux2, sel_mux4, en_a, en_b, en_c, busy, ready, done};
  assign outs1 = {sel_mux2_1, sel_mux4_1, en_a_1, en_b_1, en_c_1, busy_1,
                  ready_1, done_1};

  localparam logic [8:0] O_IDLE = 9'b0_00_000_0_1_0;
  localparam logic [8:0] O_N0   = 9'b0_00_100_1_0_0;
  localparam logic [8:0] O_D0   = 9'b0_01_011_1_0_0;
  localparam logic [8:0] O_NI   = 9'b1_10_100_1_0_0;
  localparam logic [8:0] O_DI   = 9'b1_11_011_1_0_0;
  localparam logic [8:0] O_DONE = 9'b0_00_000_0_1_1;

  // Expected outputs and counter for cycles 1..8 after start is sampled.
  logic [8:0] seq3 [1:8];
  logic [3:0] cnt3 [1:8];
  initial begin
    seq3 = '{O_N0, O_D0, O_NI, O_DI, O_NI, O_DI, O_NI, O_DONE};
    cnt3 = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2};
  end

  // ---------------------------------------------------------------------------
  // Datapath: Q1.16 values held in 17-bit registers
  // ---------------------------------------------------------------------------
  localparam logic [16:0] SEED   = 17'd49152;  // 0.75
  localparam logic [16:0] NUM    = 17'd98304;  // 1.5
  localparam logic [16:0] DENOM  = 17'd81920;  // 1.25
  localparam int          Q_EXP  = 78643;      // 1.2 * 2^16
  localparam int          Q_TOL  = 16;

  logic [16:0] reg_a, reg_b, reg_c, mux_a, mux_b, prod_hi;
  logic [33:0] prod;

  always_comb begin
    mux_a = sel_mux2 ? reg_c : SEED;
    case (sel_mux4)
      2'b00:   mux_b = NUM;
      2'b01:   mux_b = DENOM;
      2'b10:   mux_b = reg_a;
      default: mux_b = reg_b;
    endcase
    prod    = mux_a * mux_b;
    prod_hi = prod[32:16];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_a <= '0;
      reg_b <= '0;
      reg_c <= '0;
    end else begin
      if (en_a) reg_a <= prod_hi;
      if (en_b) reg_b <= prod_hi;
      if (en_c) reg_c <= ~prod_hi;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start and walk through a full ITER=3 divide (cycles
  // 1..8). The counter is checked from cycle 3 on, and also in cycles 1..2
  // when check_early is set (the counter is only known there after a reset).
  // Optional start pulses are injected in busy cycles 3 and 5.
  task automatic run_seq(input string tag, input bit check_early,
                         input bit busy_starts);
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      start = 1'b0;
      check($sformatf("%s_outs_c%0d", tag, k), 32'(outs), 32'(seq3[k]));
      if (k >= 3 || check_early)
        check($sformatf("%s_cnt_c%0d", tag, k), 32'(iter_cnt), 32'(cnt3[k]));
      if (busy_starts && (k == 3 || k == 5)) start = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    start1 = 1'b0;
    abort1 = 1'b0;

    // Reset state
    step();
    step();
    check("rst_outs", 32'(outs), 32'(O_IDLE));
    check("rst_cnt", 32'(iter_cnt), 32'd0);
    reset = 1'b0;
    step();
    check("idle_outs", 32'(outs), 32'(O_IDLE));

    // Single divide, with the datapath checked at done
    run_seq("t1", 1'b1, 1'b0);
    n_chk++;
    assert ((int'(reg_a) >= Q_EXP - Q_TOL) && (int'(reg_a) <= Q_EXP + Q_TOL))
      n_pass++;
    else begin
      n_fail++;
      $error("FAIL dp_quotient: observed=%0d expected=%0d+-%0d",
             reg_a, Q_EXP, Q_TOL);
    end
    step();
    check("t1_idle_after", 32'(outs), 32'(O_IDLE));
    check("t1_cnt_hold", 32'(iter_cnt), 32'd2);

    // start held high: back-to-back divides, done every 8 cycles
    start = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 24) start = 1'b0;
      check($sformatf("t3_outs_c%0d", k), 32'(outs), 32'(seq3[((k - 1) % 8) + 1]));
    end
    step();
    check("t3_idle_after", 32'(outs), 32'(O_IDLE));

    // abort in the DI cycle of iteration 0
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("t4_in_di", 32'(outs), 32'(O_DI));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_abort_idle", 32'(outs), 32'(O_IDLE));
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t4_quiet_%0d", k), 32'(outs), 32'(O_IDLE));
    end
    run_seq("t4_rerun", 1'b0, 1'b0);

    // abort in DONE is ignored (done already pulsed), then the FSM goes idle
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_in_done", 32'(outs), 32'(O_IDLE));

    // start together with abort in IDLE: start wins
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", 32'(outs), 32'(O_N0));
    for (int k = 2; k <= 8; k++) begin
      step();
      check($sformatf("sa_outs_c%0d", k), 32'(outs), 32'(seq3[k]));
    end
    step();
    check("sa_idle_after", 32'(outs), 32'(O_IDLE));

    // start pulses while busy are ignored
    run_seq("t5_busy", 1'b0, 1'b1);
    step();
    check("t5_idle_after", 32'(outs), 32'(O_IDLE));

    // Asynchronous reset in the middle of NI
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("t5_in_ni", 32'(outs), 32'(O_NI));
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_outs", 32'(outs), 32'(O_IDLE));
    check("async_rst_cnt", 32'(iter_cnt), 32'd0);
    step();
    reset = 1'b0;
    step();
    check("post_rst_idle", 32'(outs), 32'(O_IDLE));

    // ITER=1 instance: N0, D0, NI, DONE, then IDLE
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("i1_c1", 32'(outs1), 32'(O_N0));
    step();
    check("i1_c2", 32'(outs1), 32'(O_D0));
    step();
    check("i1_c3", 32'(outs1), 32'(O_NI));
    step();
    check("i1_c4_done", 32'(outs1), 32'(O_DONE));
    step();
    check("i1_c5_idle", 32'(outs1), 32'(O_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fpdiv_seq_ctrl.md
Name: fpdiv_seq_ctrl

Overview:
- Moore FSM that sequences the Goldschmidt divider datapath: the 2:1 multiplier-A mux, the 4:1 multiplier-B mux, and the enables of register A (quotient), register B (divisor) and register C (one's-complement correction factor).
- Runs the initial scaling by the constant seed, then ITER refinement iterations, then pulses done.
- Sits between the FP divide issue logic and the divider datapath.

Parameters:
ITER, 3, number of numerator refinement steps after initial scaling; legal 1..15
CNT_W, 4, width of iteration counter; must satisfy 2^CNT_W > ITER

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; forces IDLE and all outputs to reset values
start  in  1  request a divide; sampled only in IDLE or DONE
abort  in  1  synchronous cancel of an in-flight divide
sel_mux2  out  1  multiplier-A select: 0 = initial seed (0.75), 1 = register C
sel_mux4  out  2  multiplier-B select: 00 = num, 01 = denom, 10 = register A, 11 = register B
en_a  out  1  load register A with product high bits
en_b  out  1  load register B with product high bits
en_c  out  1  load register C with one's complement of product high bits
busy  out  1  high in every state except IDLE and DONE
ready  out  1  high in IDLE and DONE (start will be accepted)
done  out  1  one-cycle pulse; register A holds the quotient
iter_cnt  out  CNT_W  current refinement index, for debug/verification

Behaviour:
- Reset (async, any time incl. mid-operation): state=IDLE, iter_cnt=0; sel_mux2=0, sel_mux4=00, en_a=en_b=en_c=0, busy=0, done=0, ready=1.
- All outputs decode from registered state/counter only; no combinational input-to-output path.
- States and outputs (unlisted outputs = 0):
  IDLE: ready=1.
  N0: sel_mux2=0, sel_mux4=00, en_a=1 (A <= seed*num).
  D0: sel_mux2=0, sel_mux4=01, en_b=1, en_c=1 (B <= seed*denom, C <= ~seed*denom).
  NI: sel_mux2=1, sel_mux4=10, en_a=1 (A <= C*A).
  DI: sel_mux2=1, sel_mux4=11, en_b=1, en_c=1 (B <= C*B, C <= ~C*B).
  DONE: done=1, ready=1.
- Transitions (abort checked first):
  any state except IDLE/DONE with abort=1 -> IDLE, no done.
  IDLE: start -> N0; else stay.
  N0 -> D0. D0 -> NI, iter_cnt <= 0.
  NI: iter_cnt == ITER-1 -> DONE; else -> DI.
  DI -> NI, iter_cnt <= iter_cnt+1.
  DONE: start -> N0 (back-to-back); else -> IDLE.
- Final DI is never executed; the last divisor update is unnecessary.
- Latency: start sampled at edge 0 -> done high in cycle 2*ITER+2 after that edge. ITER=3 gives 8 cycles; the divider is never idle between back-to-back requests.
- start while busy: ignored, no queuing.
- abort in IDLE or DONE: ignored; DONE still pulses once.
- abort and start in IDLE in the same cycle: start accepted.
- iter_cnt holds its value in IDLE/DONE and is cleared only in D0 and by reset.
- Each enable is high only in the states listed; en_a is never high in the same cycle as en_b or en_c.

Test Plan:
1. ITER=3, reset then a 1-cycle start -> states N0,D0,NI,DI,NI,DI,NI,DONE; en_a high in cycles 1,3,5,7; en_b/en_c high in cycles 2,4,6; done only in cycle 8; sel_mux4 sequence 00,01,10,11,10,11,10.
2. Same sequence with datapath attached, num=1.5, denom=1.25 -> register A at done equals 1.2 within datapath truncation error.
3. start held high continuously -> DONE goes directly to N0; done pulses every 8 cycles; ready=1 only in DONE cycles.
4. abort asserted in the DI cycle of iteration 0 -> IDLE next cycle; all enables 0; done never pulses; a new start runs the full 8-cycle sequence.
5. reset asserted asynchronously mid-NI (between edges) -> outputs go to reset values immediately without a clock edge; start pulses while busy in another run have no effect.
6. ITER=1 -> N0,D0,NI,DONE; done in cycle 4; DI never entered.
